// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider.
// Produces one quotient bit per enabled clock. A start/busy/done handshake
// frames each division, and quotient/remainder/div_zero are registered and
// hold until the next done strobe. enable=0 freezes every register.
module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] dvd_r;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_r;      // latched divisor
    logic [WIDTH:0]   rem_r;      // partial remainder, one guard bit wide
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   rem_next_s;
    logic             qbit_s;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        shift_s    = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
        diff_s     = shift_s - {1'b0, dsr_r};
        rem_next_s = shift_s;
        qbit_s     = 1'b0;
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next_s = diff_s;
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = shift_s;
            qbit_s     = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered outputs; all frozen while enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            dvd_r     <= '0;
            dsr_r     <= '0;
            rem_r     <= '0;
            cnt_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (enable) begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_r   <= dividend;
                        dsr_r   <= divisor;
                        rem_r   <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    done  <= 1'b0;
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], qbit_s};
                    cnt_r <= cnt_r + ONE;
                    if (cnt_r == LAST) begin
                        cnt_r   <= '0;
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    quotient  <= dvd_r;
                    remainder <= rem_r[WIDTH-1:0];
                    div_zero  <= (dsr_r == '0);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq (WIDTH=8): directed scenarios plus a random sweep
// checked against plain-arithmetic division.
`timescale 1ns/1ps
module tb_div_seq;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int checks;
    int fails;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer division; divide-by-zero yields all ones and the dividend.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 8'd0) return 8'hFF;
        return 8'(int'(a) / int'(b));
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 8'd0) return a;
        return 8'(int'(a) % int'(b));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a division (accepted on the next edge) and wait for done.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int edges, output int busy_cyc);
        enable   = 1'b1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        edges    = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && edges < 60) begin
            if (busy === 1'b1) busy_cyc++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) tick();
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        end
        checks++;
        if ({quotient, remainder} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_results: got %h expected 0000", {quotient, remainder});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e, b;
        run_div(8'd200, 8'd7, e, b);
        checks++;
        if (e != 9) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 9", e);
        end
        checks++;
        if (b != 9) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d expected 9", b);
        end
        checks++;
        if (quotient !== 8'd28 || remainder !== 8'd4 || div_zero !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected q=28 r=4 dz=0",
                     quotient, remainder, div_zero);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] av [4] = '{8'd255, 8'd3, 8'd0, 8'd255};
        logic [W-1:0] bv [4] = '{8'd1, 8'd10, 8'd5, 8'd255};
        logic [W-1:0] qv [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
        logic [W-1:0] rv [4] = '{8'd0, 8'd3, 8'd0, 8'd0};
        int e, b;
        for (int i = 0; i < 4; i++) begin
            run_div(av[i], bv[i], e, b);
            checks++;
            if (e != 9 || quotient !== qv[i] || remainder !== rv[i] || div_zero !== 1'b0) begin
                fails++;
                $display("FAIL corner_%0d: got q=%0d r=%0d dz=%b lat=%0d expected q=%0d r=%0d dz=0 lat=9",
                         i, quotient, remainder, div_zero, e, qv[i], rv[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int e, b;
        run_div(8'd5, 8'd0, e, b);
        checks++;
        if (e != 9 || quotient !== 8'd255 || remainder !== 8'd5 || div_zero !== 1'b1) begin
            fails++;
            $display("FAIL div_zero: got q=%0d r=%0d dz=%b lat=%0d expected q=255 r=5 dz=1 lat=9",
                     quotient, remainder, div_zero, e);
        end
        run_div(8'd9, 8'd3, e, b);
        checks++;
        if (quotient !== 8'd3 || remainder !== 8'd0 || div_zero !== 1'b0) begin
            fails++;
            $display("FAIL div_zero_clear: got q=%0d r=%0d dz=%b expected q=3 r=0 dz=0",
                     quotient, remainder, div_zero);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [W-1:0] q_before;
        q_before = quotient;
        enable   = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            enable = (n + 1 >= 4 && n + 1 <= 6) ? 1'b0 : 1'b1;
            tick();
            n++;
            if (done !== 1'b1 && quotient !== q_before) begin
                checks++;
                fails++;
                $display("FAIL stall_hold: got q=%0d expected q=%0d", quotient, q_before);
            end
        end
        enable = 1'b1;
        checks++;
        if (n != 12) begin
            fails++;
            $display("FAIL stall_latency: got %0d expected 12", n);
        end
        checks++;
        if (quotient !== 8'd28 || remainder !== 8'd4) begin
            fails++;
            $display("FAIL stall_result: got q=%0d r=%0d expected q=28 r=4", quotient, remainder);
        end
    endtask

    task automatic test_done_stall();
        int e, b;
        run_div(8'd77, 8'd6, e, b);
        enable = 1'b0;
        repeat (3) tick();
        checks++;
        if (done !== 1'b1 || quotient !== 8'd12 || remainder !== 8'd5) begin
            fails++;
            $display("FAIL done_stretch: got done=%b q=%0d r=%0d expected done=1 q=12 r=5",
                     done, quotient, remainder);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_release: got %b expected 0", done);
        end
    endtask

    task automatic test_back_to_back();
        int n, e, b;
        enable   = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            start    = (n == 3) ? 1'b1 : 1'b0;
            dividend = 8'd50;
            divisor  = 8'd3;
            tick();
            n++;
        end
        start = 1'b0;
        checks++;
        if (n != 9 || quotient !== 8'd14 || remainder !== 8'd2) begin
            fails++;
            $display("FAIL busy_ignore: got q=%0d r=%0d lat=%0d expected q=14 r=2 lat=9",
                     quotient, remainder, n);
        end
        // done is high here: the next edge (E10) must accept a new start
        run_div(8'd9, 8'd4, e, b);
        checks++;
        if (e != 9 || quotient !== 8'd2 || remainder !== 8'd1) begin
            fails++;
            $display("FAIL back_to_back: got q=%0d r=%0d lat=%0d expected q=2 r=1 lat=9",
                     quotient, remainder, e);
        end
    endtask

    task automatic test_reset_mid();
        int e, b;
        int seen_done;
        enable   = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_zero, quotient, remainder} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid_clear: got busy=%b done=%b dz=%b q=%0d r=%0d expected all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nodone: got done_count=%0d busy=%b expected 0 0", seen_done, busy);
        end
        run_div(8'd100, 8'd9, e, b);
        checks++;
        if (e != 9 || quotient !== 8'd11 || remainder !== 8'd1) begin
            fails++;
            $display("FAIL reset_mid_after: got q=%0d r=%0d lat=%0d expected q=11 r=1 lat=9",
                     quotient, remainder, e);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, d;
        int e, b;
        int bad;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom);
            d = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            run_div(a, d, e, b);
            checks++;
            if (e != 9 || quotient !== ref_q(a, d) || remainder !== ref_r(a, d)
                || div_zero !== (d == 8'd0)) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dz=%b lat=%0d expected q=%0d r=%0d",
                             i, a, d, quotient, remainder, div_zero, e, ref_q(a, d), ref_r(a, d));
            end
            if (d != 8'd0) begin
                checks++;
                if (int'(quotient) * int'(d) + int'(remainder) != int'(a) || remainder >= d) begin
                    fails++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random_identity_%0d: %0d/%0d got q=%0d r=%0d",
                                 i, a, d, quotient, remainder);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_stall();
        test_done_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
